// File: rtl/axi_line_pkg.sv
// Shared types and constants for the AXI cache-line master.
package axi_line_pkg;

  localparam int unsigned BEAT_W = 128;
  localparam int unsigned STRB_W = BEAT_W / 8;
  localparam logic [STRB_W-1:0] STRB_ALL = 16'hFFFF;

  // AXI response codes
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW,
    ST_W,
    ST_B,
    ST_RSP
  } state_t;

endpackage

// File: rtl/axi_line_buf.sv
// Line buffer: BEATS x 128-bit storage with whole-line load, per-beat write,
// per-beat read and full-line view.
module axi_line_buf
  import axi_line_pkg::*;
#(
  parameter int unsigned BEATS = 4,
  parameter int unsigned IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                    CLK,
  input  logic                    RSTn,
  input  logic                    load,
  input  logic [BEATS*BEAT_W-1:0] load_line,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [BEAT_W-1:0]       wr_beat,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [BEAT_W-1:0]       rd_beat_c,
  output logic [BEATS*BEAT_W-1:0] line
);

  logic [BEATS-1:0][BEAT_W-1:0] mem;

  // Storage: whole-line load wins over a single-beat write
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      mem <= '0;
    end else if (load) begin
      mem <= load_line;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_beat;
    end
  end

  assign rd_beat_c = mem[rd_idx];
  assign line      = mem;

endmodule

// File: rtl/axi_line_master.sv
// AXI initiator moving one whole cache line per request as an INCR burst.
// Optional macro AXI_LINE_MASTER_CHECK_EN: accumulate RRESP/BRESP/RLAST
// problems into RSP_ERR and raise a simulation $error; otherwise RSP_ERR is 0.
module axi_line_master
  import axi_line_pkg::*;
#(
  parameter int unsigned BEATS  = 4,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                    CLK,
  input  logic                    RSTn,
  // client request/response
  input  logic                    REQ_VALID,
  output logic                    REQ_READY,
  input  logic                    REQ_WE,
  input  logic [ADDR_W-1:0]       REQ_ADDR,
  input  logic [BEATS*BEAT_W-1:0] REQ_WDATA,
  output logic                    RSP_VALID,
  output logic [BEATS*BEAT_W-1:0] RSP_RDATA,
  output logic                    RSP_ERR,
  // read address / data
  output logic                    ARVALID,
  output logic [ADDR_W-1:0]       ARADDR,
  output logic [7:0]              ARLEN,
  input  logic                    ARREADY,
  input  logic                    RVALID,
  input  logic [BEAT_W-1:0]       RDATA,
  input  logic                    RLAST,
  input  logic [1:0]              RRESP,
  output logic                    RREADY,
  // write address / data / response
  output logic                    AWVALID,
  output logic [ADDR_W-1:0]       AWADDR,
  output logic [7:0]              AWLEN,
  input  logic                    AWREADY,
  output logic                    WVALID,
  output logic [BEAT_W-1:0]       WDATA,
  output logic [STRB_W-1:0]       WSTRB,
  output logic                    WLAST,
  input  logic                    WREADY,
  input  logic                    BVALID,
  input  logic [1:0]              BRESP,
  output logic                    BREADY
);

  localparam int unsigned IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned CNT_W = $clog2(BEATS) + 1;
  localparam int unsigned OFF_W = $clog2(BEATS * BEAT_W / 8);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              err;
  logic              last_c;
  logic              r_err_c;
  logic              b_err_c;
  logic [ADDR_W-1:0] line_addr_c;
  logic              load_c;
  logic              wr_en_c;
  logic [IDX_W-1:0]  rd_idx_c;
  logic [BEAT_W-1:0] rd_beat_c;
  logic              unused_addr;

  assign ARLEN = 8'(BEATS - 1);
  assign AWLEN = 8'(BEATS - 1);
  assign WSTRB = STRB_ALL;

  // Line-aligned address; offset bits inside the line are dropped
  assign line_addr_c = {REQ_ADDR[ADDR_W-1:OFF_W], OFF_W'(0)};
  assign unused_addr = ^REQ_ADDR[OFF_W-1:0];

  assign last_c   = (cnt == CNT_W'(BEATS - 1));
  assign load_c   = (state == ST_IDLE) && REQ_VALID && REQ_READY && REQ_WE;
  assign wr_en_c  = (state == ST_R) && RVALID && RREADY;
  // W data is registered, so look one beat ahead of the counter
  assign rd_idx_c = (state == ST_W) ? IDX_W'(cnt + CNT_W'(1)) : '0;

`ifdef AXI_LINE_MASTER_CHECK_EN
  assign r_err_c = (RRESP != AXI_RESP_OKAY) || (RLAST != last_c);
  assign b_err_c = (BRESP != AXI_RESP_OKAY);

  // Simulation-time report of bad responses or misplaced RLAST
  always @(posedge CLK) begin
    if (RSTn && state == ST_R && RVALID && r_err_c)
      $error("axi_line_master: bad R beat %0d resp=%0d last=%0b", cnt, RRESP, RLAST);
    if (RSTn && state == ST_B && BVALID && b_err_c)
      $error("axi_line_master: bad B resp=%0d", BRESP);
  end
`else
  logic unused_resp;
  assign r_err_c     = 1'b0;
  assign b_err_c     = 1'b0;
  assign unused_resp = ^{RRESP, BRESP, RLAST};
`endif

  axi_line_buf #(
    .BEATS (BEATS),
    .IDX_W (IDX_W)
  ) u_buf (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .load      (load_c),
    .load_line (REQ_WDATA),
    .wr_en     (wr_en_c),
    .wr_idx    (cnt[IDX_W-1:0]),
    .wr_beat   (RDATA),
    .rd_idx    (rd_idx_c),
    .rd_beat_c (rd_beat_c),
    .line      (RSP_RDATA)
  );

  // Transaction FSM with registered AXI and client outputs
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= ST_IDLE;
      REQ_READY <= 1'b1;
      RSP_VALID <= 1'b0;
      RSP_ERR   <= 1'b0;
      ARVALID   <= 1'b0;
      ARADDR    <= '0;
      RREADY    <= 1'b0;
      AWVALID   <= 1'b0;
      AWADDR    <= '0;
      WVALID    <= 1'b0;
      WDATA     <= '0;
      WLAST     <= 1'b0;
      BREADY    <= 1'b0;
      cnt       <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (REQ_VALID && REQ_READY) begin
            REQ_READY <= 1'b0;
            cnt       <= '0;
            err       <= 1'b0;
            if (REQ_WE) begin
              AWADDR  <= line_addr_c;
              AWVALID <= 1'b1;
              state   <= ST_AW;
            end else begin
              ARADDR  <= line_addr_c;
              ARVALID <= 1'b1;
              state   <= ST_AR;
            end
          end
        end
        ST_AR: begin
          if (ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state   <= ST_R;
          end
        end
        ST_R: begin
          if (RVALID) begin
            cnt <= cnt + CNT_W'(1);
            err <= err | r_err_c;
            if (last_c) begin
              RREADY    <= 1'b0;
              RSP_VALID <= 1'b1;
              RSP_ERR   <= err | r_err_c;
              state     <= ST_RSP;
            end
          end
        end
        ST_AW: begin
          if (AWREADY) begin
            AWVALID <= 1'b0;
            WVALID  <= 1'b1;
            WDATA   <= rd_beat_c;
            WLAST   <= (BEATS == 1);
            state   <= ST_W;
          end
        end
        ST_W: begin
          if (WREADY) begin
            cnt <= cnt + CNT_W'(1);
            if (last_c) begin
              WVALID <= 1'b0;
              WLAST  <= 1'b0;
              BREADY <= 1'b1;
              state  <= ST_B;
            end else begin
              WDATA <= rd_beat_c;
              WLAST <= (cnt + CNT_W'(1) == CNT_W'(BEATS - 1));
            end
          end
        end
        ST_B: begin
          if (BVALID) begin
            BREADY    <= 1'b0;
            RSP_VALID <= 1'b1;
            RSP_ERR   <= err | b_err_c;
            state     <= ST_RSP;
          end
        end
        ST_RSP: begin
          RSP_VALID <= 1'b0;
          RSP_ERR   <= 1'b0;
          REQ_READY <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
